nx_stream_arbiter: RTL

- Merges the four inbound node streams (north, east, south, west) onto one outbound stream using round-robin arbitration.
- Holds each accepted message in a single-entry registered output stage.
- Sits in front of the nx_node message decoder and any single shared egress port. It shares that port fairly between the four directional requesters.
- Each message is a single beat, so arbitration happens on every transfer.

---
 rtl/nx_stream_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/nx_stream_arbiter.sv
// Four-way round-robin stream merger (N/E/S/W) with a single-entry registered
// output stage; one message per transfer, full throughput when downstream is ready.
module nx_stream_arbiter #(
    parameter int STREAM_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] ib_north_data_i,
    input  logic                    ib_north_valid_i,
    output logic                    ib_north_ready_o,
    input  logic [STREAM_WIDTH-1:0] ib_east_data_i,
    input  logic                    ib_east_valid_i,
    output logic                    ib_east_ready_o,
    input  logic [STREAM_WIDTH-1:0] ib_south_data_i,
    input  logic                    ib_south_valid_i,
    output logic                    ib_south_ready_o,
    input  logic [STREAM_WIDTH-1:0] ib_west_data_i,
    input  logic                    ib_west_valid_i,
    output logic                    ib_west_ready_o,
    output logic [STREAM_WIDTH-1:0] ob_data_o,
    output logic [1:0]              ob_dir_o,
    output logic                    ob_valid_o,
    input  logic                    ob_ready_i,
    output logic                    idle_o
);

    logic [3:0]              req_vec;
    logic [3:0]              ready_vec;
    logic [1:0]              last_p0;
    logic                    vld_p0;
    logic [STREAM_WIDTH-1:0] data_p0;
    logic [1:0]              dir_p0;
    logic                    slot_free;
    logic                    grant_any;
    logic [1:0]              grant_dir;
    logic [1:0]              scan_idx;
    logic                    accept;
    logic [STREAM_WIDTH-1:0] grant_data;

    assign req_vec   = {ib_west_valid_i, ib_south_valid_i, ib_east_valid_i, ib_north_valid_i};
    assign slot_free = !vld_p0 || ob_ready_i;

    // Scan starts one past the last winner and wraps, so the winner drops to lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_dir = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_p0 + 2'(k);
            if (!grant_any && req_vec[scan_idx]) begin
                grant_any = 1'b1;
                grant_dir = scan_idx;
            end
        end
    end

    // Gating on rst_i keeps every ready low while reset is held, independent of the clock.
    assign ready_vec = (grant_any && slot_free && rst_i) ? (4'b0001 << grant_dir) : 4'b0000;
    assign accept    = |ready_vec;

    assign ib_north_ready_o = ready_vec[0];
    assign ib_east_ready_o  = ready_vec[1];
    assign ib_south_ready_o = ready_vec[2];
    assign ib_west_ready_o  = ready_vec[3];

    always_comb begin
        grant_data = ib_north_data_i;
        case (grant_dir)
            2'd1:    grant_data = ib_east_data_i;
            2'd2:    grant_data = ib_south_data_i;
            2'd3:    grant_data = ib_west_data_i;
            default: grant_data = ib_north_data_i;
        endcase
    end

    // Stage p0: output register; an accept overrides a drain so there is no bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            dir_p0  <= 2'd0;
            last_p0 <= 2'd3;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= grant_data;
            dir_p0  <= grant_dir;
            last_p0 <= grant_dir;
        end else if (ob_ready_i) begin
            vld_p0  <= 1'b0;
        end
    end

    assign ob_valid_o = vld_p0;
    assign ob_data_o  = data_p0;
    assign ob_dir_o   = dir_p0;
    assign idle_o     = !vld_p0 && (req_vec == 4'b0000);

endmodule
